// File: rtl/deppmaster.sv
// Host-side EPP master: one 32-bit read/write command -> byte-wide EPP strobe sequence.
// Define DEPPMASTER_TIMEOUT_EN to abort a strobe/release phase after TIMEOUT_CYCLES clocks.
module deppmaster #(
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_stb,
    input  logic        i_cmd_we,
    input  logic [31:0] i_cmd_addr,
    input  logic [31:0] i_cmd_data,
    output logic        o_cmd_busy,
    output logic        o_rsp_stb,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic        o_astb_n,
    output logic        o_dstb_n,
    output logic        o_write_n,
    output logic [7:0]  o_depp,
    output logic        o_depp_oe,
    input  logic [7:0]  i_depp,
    input  logic        i_wait
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_RELEASE, S_DONE} state_t;

    localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

    state_t            r_state, w_next;
    logic [SW-1:0]     r_setup_cnt;
    logic [4:0]        r_cyc, w_cyc_nxt;
    logic              r_we;
    logic [31:0]       r_addr, r_data, r_rdata;
    logic              r_wait_s1, r_wait_s2;
    logic              r_astb_n, r_dstb_n, r_write_n, r_depp_oe;
    logic [7:0]        r_depp;
    logic              r_busy, r_rsp_stb, r_rsp_err;
    logic [31:0]       r_rsp_data;
    logic              w_accept, w_last, w_setup_done, w_tmo, w_abort;
    logic              w_is_addr, w_rd;
    logic [7:0]        w_byte;
    logic [7:0][7:0]   w_bytes;

    assign w_bytes      = {r_addr, r_data};
    assign w_accept     = i_cmd_stb && !r_busy && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last       = r_we ? (r_cyc == 5'd15) : (r_cyc == 5'd17);
    assign w_setup_done = (r_setup_cnt == SW'(SETUP_CYCLES - 1));

`ifdef DEPPMASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo;

    assign w_tmo = (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || w_next != r_state)
            r_tmo <= '0;
        else if (r_state == S_STROBE || r_state == S_RELEASE)
            r_tmo <= r_tmo + 1'b1;
        else
            r_tmo <= '0;
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
    assign w_tmo        = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: w_next = w_accept ? S_SETUP : S_IDLE;
            S_SETUP:        if (w_setup_done) w_next = S_STROBE;
            S_STROBE: begin
                if (r_wait_s2) w_next = S_RELEASE;
                else if (w_tmo) begin
                    w_next  = S_DONE;
                    w_abort = 1'b1;
                end
            end
            S_RELEASE: begin
                if (!r_wait_s2) w_next = w_last ? S_DONE : S_SETUP;
                else if (w_tmo) begin
                    w_next  = S_DONE;
                    w_abort = 1'b1;
                end
            end
            default:        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cyc_nxt = r_cyc;
        if (w_accept)
            w_cyc_nxt = 5'd0;
        else if (r_state == S_RELEASE && w_next == S_SETUP)
            w_cyc_nxt = r_cyc + 5'd1;
    end

    // Per-EPP-cycle decode: even cycles are address writes, odd cycles data phases.
    // Reads detour through reg 8 (launch) after the address bytes.
    always_comb begin
        w_is_addr = ~w_cyc_nxt[0];
        w_rd      = 1'b0;
        w_byte    = 8'h00;
        if (r_we || w_cyc_nxt < 5'd8) begin
            if (w_is_addr) w_byte = {5'd0, w_cyc_nxt[3:1]};
            else           w_byte = w_bytes[~w_cyc_nxt[3:1]];
        end else if (w_cyc_nxt == 5'd8) begin
            w_byte = 8'h08;
        end else if (w_cyc_nxt == 5'd9) begin
            w_byte = 8'h00;
        end else if (w_is_addr) begin
            w_byte = {4'd0, w_cyc_nxt[4:1] - 4'd1};
        end else begin
            w_rd = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait_s1   <= 1'b0;
            r_wait_s2   <= 1'b0;
            r_setup_cnt <= '0;
            r_cyc       <= 5'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'h0;
            r_data      <= 32'h0;
            r_rdata     <= 32'h0;
        end else begin
            r_wait_s1   <= i_wait;
            r_wait_s2   <= r_wait_s1;
            r_setup_cnt <= (r_state == S_SETUP) ? r_setup_cnt + 1'b1 : '0;
            r_cyc       <= w_cyc_nxt;
            if (w_accept) begin
                r_we    <= i_cmd_we;
                r_addr  <= i_cmd_addr;
                r_data  <= i_cmd_data;
                r_rdata <= 32'h0;
            end else if (r_state == S_STROBE && r_wait_s2 && w_rd) begin
                r_rdata <= {r_rdata[23:0], i_depp};
            end
        end
    end

    // Bus outputs are registered from the next state so strobes never glitch
    // and data/direction only move while both strobes are high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_astb_n   <= 1'b1;
            r_dstb_n   <= 1'b1;
            r_write_n  <= 1'b1;
            r_depp     <= 8'h00;
            r_depp_oe  <= 1'b0;
            r_busy     <= 1'b0;
            r_rsp_stb  <= 1'b0;
            r_rsp_data <= 32'h0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_rsp_stb <= 1'b0;
            case (w_next)
                S_SETUP: begin
                    r_astb_n  <= 1'b1;
                    r_dstb_n  <= 1'b1;
                    r_depp    <= w_byte;
                    r_write_n <= w_rd;
                    r_depp_oe <= ~w_rd;
                    r_busy    <= 1'b1;
                end
                S_STROBE: begin
                    r_astb_n <= ~w_is_addr;
                    r_dstb_n <= w_is_addr;
                end
                S_RELEASE: begin
                    r_astb_n <= 1'b1;
                    r_dstb_n <= 1'b1;
                end
                S_DONE: begin
                    r_astb_n   <= 1'b1;
                    r_dstb_n   <= 1'b1;
                    r_write_n  <= 1'b1;
                    r_depp     <= 8'h00;
                    r_depp_oe  <= 1'b0;
                    r_busy     <= 1'b0;
                    r_rsp_stb  <= 1'b1;
                    r_rsp_err  <= w_abort;
                    r_rsp_data <= (w_abort || r_we) ? 32'h0 : r_rdata;
                end
                default: begin
                    r_astb_n  <= 1'b1;
                    r_dstb_n  <= 1'b1;
                    r_write_n <= 1'b1;
                    r_depp    <= 8'h00;
                    r_depp_oe <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmd_busy = r_busy;
    assign o_rsp_stb  = r_rsp_stb;
    assign o_rsp_data = r_rsp_data;
    assign o_rsp_err  = r_rsp_err;
    assign o_astb_n   = r_astb_n;
    assign o_dstb_n   = r_dstb_n;
    assign o_write_n  = r_write_n;
    assign o_depp     = r_depp;
    assign o_depp_oe  = r_depp_oe;

endmodule

// File: tb/tb_deppmaster.sv
// Bench for deppmaster: EPP bridge model, expected EPP byte stream built from the register map.
module tb_deppmaster;
    localparam int SETUP = 1;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        i_rst, i_cmd_stb, i_cmd_we, i_wait;
    logic [31:0] i_cmd_addr, i_cmd_data;
    logic [7:0]  i_depp;
    logic        o_cmd_busy, o_rsp_stb, o_rsp_err, o_astb_n, o_dstb_n, o_write_n, o_depp_oe;
    logic [31:0] o_rsp_data;
    logic [7:0]  o_depp;

    always #5 clk = ~clk;

    deppmaster #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_cmd_stb(i_cmd_stb), .i_cmd_we(i_cmd_we),
        .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .o_cmd_busy(o_cmd_busy),
        .o_rsp_stb(o_rsp_stb), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
        .o_astb_n(o_astb_n), .o_dstb_n(o_dstb_n), .o_write_n(o_write_n),
        .o_depp(o_depp), .o_depp_oe(o_depp_oe), .i_depp(i_depp), .i_wait(i_wait)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // kind: 0 = address write, 1 = data write, 2 = data read
    typedef struct { int kind; logic [7:0] val; logic oe; } ev_t;
    ev_t log_q[$];
    ev_t exp_q[$];

    // Bridge model: acks a strobe bdelay+1 clocks after seeing it, releases likewise.
    int          bdelay = 0;
    bit          bstuck = 1'b0;
    logic [31:0] brd    = 32'h0;
    logic [3:0]  breg;
    int          bcnt;

    always @(posedge clk) begin
        if (i_rst) begin
            i_wait <= 1'b0;
            i_depp <= 8'h00;
            bcnt   <= 0;
            breg   <= 4'd0;
        end else if (!o_astb_n || !o_dstb_n) begin
            if (!i_wait) begin
                if (!bstuck && bcnt >= bdelay) begin
                    i_wait <= 1'b1;
                    bcnt   <= 0;
                    if (!o_astb_n) begin
                        breg <= o_depp[3:0];
                        log_q.push_back('{0, o_depp, o_depp_oe});
                    end else if (!o_write_n) begin
                        log_q.push_back('{1, o_depp, o_depp_oe});
                    end else begin
                        i_depp <= brd[8*(7-int'(breg)) +: 8];
                        log_q.push_back('{2, brd[8*(7-int'(breg)) +: 8], o_depp_oe});
                    end
                end else begin
                    bcnt <= bcnt + 1;
                end
            end
        end else if (i_wait) begin
            if (bcnt >= bdelay) begin
                i_wait <= 1'b0;
                bcnt   <= 0;
            end else begin
                bcnt <= bcnt + 1;
            end
        end else begin
            bcnt <= 0;
        end
    end

    // Bus rule monitor: never both strobes low; no strobe falls while data/direction change.
    int   viol = 0;
    logic p_astb = 1'b1, p_dstb = 1'b1, p_wn = 1'b1;
    logic [7:0] p_depp = 8'h00;
    always @(negedge clk) begin
        if (!o_astb_n && !o_dstb_n) viol++;
        if (((p_astb && !o_astb_n) || (p_dstb && !o_dstb_n)) &&
            (p_depp !== o_depp || p_wn !== o_write_n)) viol++;
        p_astb = o_astb_n;
        p_dstb = o_dstb_n;
        p_wn   = o_write_n;
        p_depp = o_depp;
    end

    task automatic build_exp(input bit we, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] rd);
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{0, 8'(k), 1'b1});
            exp_q.push_back('{1, a[31-8*k -: 8], 1'b1});
        end
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back('{0, 8'(k+4), 1'b1});
                exp_q.push_back('{1, d[31-8*k -: 8], 1'b1});
            end
        end else begin
            exp_q.push_back('{0, 8'h08, 1'b1});
            exp_q.push_back('{1, 8'h00, 1'b1});
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back('{0, 8'(k+4), 1'b1});
                exp_q.push_back('{2, rd[31-8*k -: 8], 1'b0});
            end
        end
    endtask

    task automatic run_cmd(input string nm, input bit we, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rd, input int dly,
                           input bit poke);
        int  cyc;
        bit  got;
        int  n_ev;
        bdelay = dly;
        brd    = rd;
        log_q.delete();
        build_exp(we, a, d, rd);
        n_ev = exp_q.size();
        @(negedge clk);
        i_cmd_stb = 1'b1; i_cmd_we = we; i_cmd_addr = a; i_cmd_data = d;
        @(negedge clk);
        i_cmd_stb = 1'b0;
        check({nm, ".busy_after_accept"}, 64'(o_cmd_busy), 64'd1);
        cyc = 0;
        got = 1'b0;
        while (cyc < 5000 && !got) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 30) begin
                i_cmd_stb = 1'b1; i_cmd_we = ~we; i_cmd_addr = 32'hFFFF_FFFF; i_cmd_data = 32'h5A5A_5A5A;
            end else begin
                i_cmd_stb = 1'b0;
            end
            if (o_rsp_stb) got = 1'b1;
        end
        i_cmd_stb = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.rsp_timeout: no o_rsp_stb within %0d clocks", nm, cyc);
            return;
        end
        check({nm, ".rsp_data"}, 64'(o_rsp_data), we ? 64'd0 : 64'(rd));
        check({nm, ".rsp_err"}, 64'(o_rsp_err), 64'd0);
        check({nm, ".busy_at_rsp"}, 64'(o_cmd_busy), 64'd0);
        check({nm, ".strobes_at_rsp"}, 64'({o_astb_n, o_dstb_n}), 64'd3);
        // Each EPP cycle: setup + two phases of (bridge latency 1+dly, 2-flop sync, 1 transition).
        check({nm, ".clocks"}, 64'(cyc), 64'(n_ev * (SETUP + 8 + 2*dly)));
        check({nm, ".ev_count"}, 64'(log_q.size()), 64'(n_ev));
        for (int i = 0; i < n_ev && i < log_q.size(); i++)
            check($sformatf("%s.ev%0d", nm, i),
                  64'({8'(log_q[i].kind), log_q[i].val, 7'd0, log_q[i].oe}),
                  64'({8'(exp_q[i].kind), exp_q[i].val, 7'd0, exp_q[i].oe}));
        @(negedge clk);
        check({nm, ".rsp_pulse_one_clk"}, 64'({o_rsp_stb, o_cmd_busy}), 64'd0);
    endtask

    typedef struct { bit we; logic [31:0] a; logic [31:0] d; logic [31:0] rd; int dly; bit poke; } vec_t;
    vec_t vecs[6];

    initial begin
        int  cyc;
        bit  got;
        vecs[0] = '{1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0,         0,  1'b0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 0,  1'b0};
        vecs[2] = '{1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0,         20, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 20, 1'b0};
        vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0,         1,  1'b1};
        vecs[5] = '{1'b0, 32'h8000_0001, 32'h1111_1111, 32'h0123_4567, 0,  1'b1};

        i_rst = 1'b1; i_cmd_stb = 1'b0; i_cmd_we = 1'b0; i_cmd_addr = 32'h0; i_cmd_data = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_state",
              64'({o_astb_n, o_dstb_n, o_write_n, o_depp, o_depp_oe, o_cmd_busy, o_rsp_stb, o_rsp_err, o_rsp_data}),
              64'({1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}));
        i_rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_cmd($sformatf("vec%0d", i), vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].rd,
                    vecs[i].dly, vecs[i].poke);

        for (int i = 0; i < 10; i++)
            run_cmd($sformatf("rnd%0d", i), 1'($urandom), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), 1'b0);

        // Reset pulsed while the fifth EPP cycle of a write is in progress.
        bdelay = 2;
        log_q.delete();
        @(negedge clk);
        i_cmd_stb = 1'b1; i_cmd_we = 1'b1; i_cmd_addr = 32'hA5A5_0000; i_cmd_data = 32'h1234_5678;
        @(negedge clk);
        i_cmd_stb = 1'b0;
        cyc = 0;
        while (cyc < 2000 && log_q.size() < 5) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid.reached_cycle5", 64'(log_q.size() >= 5), 64'd1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("rst_mid.outputs",
              64'({o_astb_n, o_dstb_n, o_write_n, o_depp, o_depp_oe, o_cmd_busy, o_rsp_stb, o_rsp_err, o_rsp_data}),
              64'({1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}));
        got = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (o_rsp_stb || o_cmd_busy) got = 1'b1;
        end
        check("rst_mid.quiet_after", 64'(got), 64'd0);
        run_cmd("after_rst", 1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);

`ifdef DEPPMASTER_TIMEOUT_EN
        bstuck = 1'b1;
        @(negedge clk);
        i_cmd_stb = 1'b1; i_cmd_we = 1'b1; i_cmd_addr = 32'h1; i_cmd_data = 32'h2;
        @(negedge clk);
        i_cmd_stb = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (cyc < 2000 && !got) begin
            @(negedge clk);
            cyc++;
            if (o_rsp_stb) got = 1'b1;
        end
        check("tmo.rsp_seen", 64'(got), 64'd1);
        check("tmo.err_data_strobes", 64'({o_rsp_err, o_rsp_data, o_astb_n, o_dstb_n, o_depp_oe}),
              64'({1'b1, 32'h0, 1'b1, 1'b1, 1'b0}));
        bstuck = 1'b0;
        repeat (10) @(negedge clk);
        run_cmd("after_tmo", 1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
`endif

        check("bus_rules", 64'(viol), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/deppmaster.md
# deppmaster

Host-side EPP (DEPP) bus master that turns one 32-bit read or write command into the byte-wide EPP address/data strobe sequence consumed by the DEPP-to-Wishbone bridge. It sits directly upstream of the bridge: in the FPGA test harness it drives the bridge's `i_astb_n`/`i_dstb_n`/`i_write_n`/`i_depp` and watches its `o_wait`/`o_depp`. It returns the read data or error to the command issuer.

## Interface
- `SETUP_CYCLES`, 1: clocks data/write_n are held stable before a strobe falls (≥1).
- `TIMEOUT_CYCLES`, 1024: clocks allowed per strobe phase before abort (only with timeout feature).
- `i_clk` in 1: the only clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_cmd_stb` in 1: command valid; accepted when `o_cmd_busy`=0.
- `i_cmd_we` in 1: 1 = write, 0 = read.
- `i_cmd_addr` in 32: Wishbone address.
- `i_cmd_data` in 32: write data.
- `o_cmd_busy` out 1: command in progress.
- `o_rsp_stb` out 1: one-clock completion pulse.
- `o_rsp_data` out 32: read data (0 for writes/errors), valid with `o_rsp_stb`.
- `o_rsp_err` out 1: timeout abort, valid with `o_rsp_stb`.
- `o_astb_n`, `o_dstb_n`, `o_write_n` out 1 each: EPP strobes, active low.
- `o_depp` out 8: byte to bridge; `o_depp_oe` out 1: drive enable.
- `i_depp` in 8: byte from bridge; `i_wait` in 1: bridge wait/ack.

## Operation
- EPP register map at bridge: regs 0–3 = address bytes, reg0 = addr[31:24]; regs 4–7 = data bytes, reg4 = data[31:24]; data write to reg 7 launches WB write; data write (value 0x00) to reg 8 launches WB read.
- One EPP cycle: addr-write (`o_astb_n`, drives reg index) or data-write/data-read (`o_dstb_n`).
- Write command: for k=0..7: addr-write k, data-write byte k → 16 EPP cycles.
- Read command: k=0..3 addr-write/data-write; addr-write 8, data-write 0x00; k=4..7 addr-write k, data-read → 18 EPP cycles; read bytes assembled big-endian.
- FSM: IDLE → SETUP → STROBE → RELEASE → (next cycle: SETUP | last: DONE) → IDLE.
  - SETUP: strobes high, `o_write_n`/`o_depp`/`o_depp_oe` set for the cycle; held SETUP_CYCLES clocks.
  - STROBE: selected strobe low until synchronized `i_wait`=1; data-read samples `i_depp` on that clock.
  - RELEASE: strobes high; wait synchronized `i_wait`=0.
  - DONE: `o_rsp_stb`=1 one clock, `o_cmd_busy` drops the same clock.
- `i_wait` passes through a 2-flop synchronizer; `i_depp` sampled once wait-sync is high (bridge holds it stable).
- `o_depp_oe`=0 and `o_write_n`=1 for data-read cycles; 1/0 otherwise.
- `i_cmd_stb` while busy ignored; command fields latched at acceptance.

## Timing
- Reset values: `o_astb_n`=`o_dstb_n`=`o_write_n`=1, `o_depp`=0x00, `o_depp_oe`=0, `o_cmd_busy`=0, `o_rsp_stb`=0, `o_rsp_data`=0, `o_rsp_err`=0, FSM IDLE.
- Acceptance: `o_cmd_busy`=1 the clock after `i_cmd_stb`; SETUP begins that clock.
- Per EPP cycle minimum (bridge answers immediately): SETUP_CYCLES + 3 (STROBE incl. sync) + 3 (RELEASE) clocks.
- `i_rst` mid-command: all outputs return to reset values next clock, no `o_rsp_stb`.
- Strobes never both low; a strobe never falls in the same clock `o_depp`/`o_write_n` changes.

## Configuration
- `DEPPMASTER_TIMEOUT_EN` defined: counter runs in STROBE and RELEASE, cleared on entry to each; reaching TIMEOUT_CYCLES releases strobes, clears `o_depp_oe`, goes DONE with `o_rsp_err`=1, `o_rsp_data`=0.
- Undefined: no counter; STROBE/RELEASE wait indefinitely; `o_rsp_err` constant 0.

## Test plan
- Write addr 0x00001234 data 0xDEADBEEF, bridge model acks → 16 cycles, bytes 00,00,12,34,DE,AD,BE,EF to regs 0–7 in order, `o_rsp_err`=0.
- Read addr 0x00000010, model returns 0xCAFEF00D → 18 cycles, reg 8 written 0x00, `o_rsp_data`=0xCAFEF00D, `o_depp_oe`=0 during reads.
- Bridge delays `i_wait` 20 clocks per phase → strobe held low until wait seen; result unchanged.
- With `DEPPMASTER_TIMEOUT_EN`, TIMEOUT_CYCLES=16, `i_wait` stuck 0 → `o_rsp_stb` with `o_rsp_err`=1, strobes high.
- `i_rst` pulsed during cycle 5 of a write → all outputs reset values next clock; new command then completes normally.
- `i_cmd_stb` asserted while busy → ignored, only first command's bytes appear.
